// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. Scans two WIDTH-bit operands MSB-first,
//   DIGIT bits per clock, and registers a one-hot verdict on out:
//     100 = a>b, 010 = a==b, 001 = a<b.
//   SIGNED=1 turns the compare into two's-complement by flipping the sign bit
//   of both operands at capture (offset binary), so every chunk compare stays
//   unsigned.
//
//   Optional feature macro: SEQ_CMP_EARLY_EXIT_EN
//     defined   : the scan stops at the first differing chunk (latency 1..N).
//     undefined : the scan always runs all N chunks (fixed latency N). The
//                 first differing chunk's verdict is held internally and is
//                 never overridden by later chunks.
module seq_magnitude_comparator #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       out
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  localparam logic [2:0] V_GT   = 3'b100;
  localparam logic [2:0] V_EQ   = 3'b010;
  localparam logic [2:0] V_LT   = 3'b001;
  localparam logic [2:0] V_NONE = 3'b000;

  // Operand width must split into whole chunks.
  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_width_check
    $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Map an operand into the unsigned compare domain. In signed mode the sign
  // bit is flipped so that the most negative value becomes all-zeros.
  function automatic logic [WIDTH-1:0] to_cmp_domain(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (SIGNED != 0) begin
      r[WIDTH-1] = ~v[WIDTH-1];
    end
    return r;
  endfunction

  // One-hot verdict of a single unsigned chunk compare.
  function automatic logic [2:0] chunk_verdict(input logic [DIGIT-1:0] ca,
                                               input logic [DIGIT-1:0] cb);
    logic [2:0] v;
    if (ca > cb) begin
      v = V_GT;
    end else if (ca < cb) begin
      v = V_LT;
    end else begin
      v = V_EQ;
    end
    return v;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [IDXW-1:0]  idx;
  logic [2:0]       out_q;

  logic [DIGIT-1:0] chunk_a;
  logic [DIGIT-1:0] chunk_b;
  logic [2:0]       chunk_v;
  logic             chunk_ne;
  logic             last_chunk;
  logic             accept;

  // The chunk under test is always the top DIGIT bits of the shift registers.
  assign chunk_a    = sh_a[WIDTH-1 -: DIGIT];
  assign chunk_b    = sh_b[WIDTH-1 -: DIGIT];
  assign chunk_v    = chunk_verdict(chunk_a, chunk_b);
  assign chunk_ne   = (chunk_v != V_EQ);
  assign last_chunk = (idx == LAST_IDX);

  // A start is honoured in IDLE and in DONE (back-to-back), never while scanning.
  assign accept = start && (state_q != S_SCAN);

  assign busy = (state_q == S_SCAN);
  assign done = (state_q == S_DONE);
  assign out  = out_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
        if (chunk_ne || last_chunk) begin
          state_d = S_DONE;
        end
`else
        if (last_chunk) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = start ? S_SCAN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef SEQ_CMP_EARLY_EXIT_EN

  // Operand capture, chunk shifting and verdict load; exits on the first difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      idx   <= '0;
      out_q <= V_NONE;
    end else if (accept) begin
      sh_a  <= to_cmp_domain(a);
      sh_b  <= to_cmp_domain(b);
      idx   <= '0;
      out_q <= V_NONE;
    end else if (state_q == S_SCAN) begin
      sh_a <= sh_a << DIGIT;
      sh_b <= sh_b << DIGIT;
      idx  <= idx + 1'b1;
      if (chunk_ne || last_chunk) begin
        // chunk_v is already 010 when the final chunk is equal.
        out_q <= chunk_v;
      end
    end
  end

`else

  // First differing verdict seen so far; V_NONE while every chunk has matched.
  logic [2:0] first_q;

  // Operand capture, chunk shifting and verdict load after a full-length scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      idx     <= '0;
      out_q   <= V_NONE;
      first_q <= V_NONE;
    end else if (accept) begin
      sh_a    <= to_cmp_domain(a);
      sh_b    <= to_cmp_domain(b);
      idx     <= '0;
      out_q   <= V_NONE;
      first_q <= V_NONE;
    end else if (state_q == S_SCAN) begin
      sh_a <= sh_a << DIGIT;
      sh_b <= sh_b << DIGIT;
      idx  <= idx + 1'b1;
      if ((first_q == V_NONE) && chunk_ne) begin
        first_q <= chunk_v;
      end
      if (last_chunk) begin
        // Earlier difference wins; otherwise the final chunk decides (or 010).
        out_q <= (first_q != V_NONE) ? first_q : chunk_v;
      end
    end
  end

`endif

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2, N=4).
// One unsigned and one signed instance share clock and reset.
module tb_seq_magnitude_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start_u, start_s;
  logic [7:0] a_u, b_u, a_s, b_s;
  logic       busy_u, done_u, busy_s, done_s;
  logic [2:0] out_u, out_s;

  int errors = 0;
  int checks = 0;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .out(out_u)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .out(out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sgn, input logic st, input logic [7:0] av, input logic [7:0] bv);
    if (sgn) begin
      start_s = st; a_s = av; b_s = bv;
    end else begin
      start_u = st; a_u = av; b_u = bv;
    end
  endtask

  function automatic logic busy_of(input bit sgn);
    return sgn ? busy_s : busy_u;
  endfunction

  function automatic logic done_of(input bit sgn);
    return sgn ? done_s : done_u;
  endfunction

  function automatic logic [2:0] out_of(input bit sgn);
    return sgn ? out_s : out_u;
  endfunction

  // One compare; k is the 0-based deciding chunk (3 for equal operands).
  task automatic run_cmp(input string tag, input bit sgn, input logic [7:0] av,
                         input logic [7:0] bv, input logic [2:0] exp_out, input int k);
    int lat;
    int exp_lat;
    exp_lat = EE ? (k + 1) : 4;
    drive(sgn, 1'b1, av, bv);
    tick();
    drive(sgn, 1'b0, 8'h00, 8'h00);
    chk({tag, "/busy_scan"}, 8'(busy_of(sgn)), 8'd1);
    chk({tag, "/out_clear"}, 8'(out_of(sgn)), 8'd0);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (done_of(sgn)) begin
        lat = i;
        break;
      end
    end
    chk({tag, "/latency"}, 8'(lat), 8'(exp_lat));
    chk({tag, "/out"}, 8'(out_of(sgn)), 8'(exp_out));
    chk({tag, "/busy_done"}, 8'(busy_of(sgn)), 8'd0);
    tick();
    chk({tag, "/done_pulse"}, 8'(done_of(sgn)), 8'd0);
    chk({tag, "/out_hold"}, 8'(out_of(sgn)), 8'(exp_out));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    chk("rst/busy", 8'(busy_u), 8'd0);
    chk("rst/done", 8'(done_u), 8'd0);
    chk("rst/out", 8'(out_u), 8'd0);
    chk("rst/out_s", 8'(out_s), 8'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Equal operands, cycle by cycle.
    drive(1'b0, 1'b1, 8'hA5, 8'hA5);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("eq/e0_busy", 8'(busy_u), 8'd1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("eq/mid_busy", 8'(busy_u), 8'd1);
      chk("eq/mid_done", 8'(done_u), 8'd0);
    end
    tick();
    chk("eq/e4_done", 8'(done_u), 8'd1);
    chk("eq/e4_busy", 8'(busy_u), 8'd0);
    chk("eq/e4_out", 8'(out_u), 8'h02);
    tick();
    chk("eq/e5_done", 8'(done_u), 8'd0);
    chk("eq/e5_out", 8'(out_u), 8'h02);

    // Unsigned verdicts.
    run_cmp("u_top", 1'b0, 8'h80, 8'h7F, 3'b100, 0);
    run_cmp("u_first_wins", 1'b0, 8'h4F, 8'h8C, 3'b001, 0);
    run_cmp("u_low_gt", 1'b0, 8'h12, 8'h11, 3'b100, 3);
    run_cmp("u_mid_lt", 1'b0, 8'h13, 8'h23, 3'b001, 1);

    // Signed verdicts.
    run_cmp("s_min_max", 1'b1, 8'h80, 8'h7F, 3'b001, 0);
    run_cmp("s_m1_m2", 1'b1, 8'hFF, 8'hFE, 3'b100, 3);
    run_cmp("s_p5_m5", 1'b1, 8'h05, 8'hFB, 3'b100, 0);
    run_cmp("s_eq_min", 1'b1, 8'h80, 8'h80, 3'b010, 3);

    // Start held through the scan is ignored; start in DONE is accepted.
    drive(1'b0, 1'b1, 8'h10, 8'h11);
    tick();
    a_u = 8'h22;
    b_u = 8'h22;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("b2b/scan1_busy", 8'(busy_u), 8'd1);
      chk("b2b/scan1_done", 8'(done_u), 8'd0);
    end
    tick();
    chk("b2b/first_done", 8'(done_u), 8'd1);
    chk("b2b/first_out", 8'(out_u), 8'h01);
    tick();
    start_u = 1'b0;
    chk("b2b/accept_busy", 8'(busy_u), 8'd1);
    chk("b2b/accept_done", 8'(done_u), 8'd0);
    chk("b2b/accept_clr", 8'(out_u), 8'd0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("b2b/scan2_done", 8'(done_u), 8'd0);
    end
    tick();
    chk("b2b/second_done", 8'(done_u), 8'd1);
    chk("b2b/second_out", 8'(out_u), 8'h02);
    tick();

    // Reset in the middle of a scan.
    drive(1'b0, 1'b1, 8'h01, 8'h02);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("rmid/pre_busy", 8'(busy_u), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid/busy", 8'(busy_u), 8'd0);
    chk("rmid/done", 8'(done_u), 8'd0);
    chk("rmid/out", 8'(out_u), 8'd0);
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      chk("rmid/no_done", 8'(done_u), 8'd0);
      chk("rmid/idle", 8'(busy_u), 8'd0);
    end
    run_cmp("u_after_rst", 1'b0, 8'h03, 8'h01, 3'b100, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator; the successor to the 3-bit combinational comparator.
- Compares two WIDTH-bit operands, MSB-first, DIGIT bits per clock.
- Supports unsigned and two's-complement modes, uses a start/busy/done handshake, and registers a one-hot result.
- Sits between operand registers and control logic that needs a>b, a==b, a<b verdicts on wide buses without a long combinational compare chain.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT, otherwise elaboration fails.
- DIGIT, 2, bits compared per scan cycle; N = WIDTH/DIGIT scan cycles.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse; out is valid from this cycle.
- out  out  3  one-hot result: 100 = a>b, 010 = a==b, 001 = a<b.

Behaviour:
- Reset: rst_n low asynchronously clears state to IDLE, busy=0, done=0, out=000, operand and index registers to 0. Takes effect immediately, including mid-scan. No result is produced for an aborted compare.
- States:
  - IDLE: start=1 on an edge captures a and b into shift registers, clears the chunk index, and moves to SCAN with busy=1.
  - SCAN: each edge compares the top DIGIT bits of both shift registers.
    - Unequal chunk: verdict is decided as 100 or 001, loaded into out; move to DONE.
    - Equal chunk: shift both registers left by DIGIT and increment the index. If the index reaches N-1 with every chunk equal, load out=010 and move to DONE.
  - DONE: busy=0 and done=1 for exactly one cycle. A start in this cycle is accepted (back-to-back). Otherwise the next state is IDLE.
- Signed mode: the sign bit of both operands is inverted at capture (offset binary). After that, chunk compares are unsigned everywhere.
- Latency: with start accepted at edge 0, the deciding chunk k (0-based) is evaluated at edge k+1, and done is high in the cycle after that edge.
  - Maximum latency is N edges, which also applies to equality. Feature-dependent behaviour is described under Optional Feature.
- start while busy=1 is ignored; it is not queued.
- a and b are don't-care after capture.
- out holds the last verdict until the next accepted start, then clears to 000 on that edge. done is low except in the DONE cycle.
- Illegal encodings (011, 101, 110, 111) never appear on out.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: SCAN exits as soon as a chunk differs, so done follows edge k+1. This gives variable latency of 1..N edges.
- Undefined:
  - The first differing chunk's verdict is latched internally, and later chunks never override it.
  - SCAN always runs all N chunks, so done always follows edge N, giving fixed latency.
  - out reflects the first differing chunk, or 010 if none differs.

Test Plan (WIDTH=8, DIGIT=2, N=4):
- Equal operands: SIGNED=0, a=0xA5, b=0xA5, start at edge 0 -> busy=1 on edges 1..3; after edge 4, out=010, done=1 for one cycle, busy=0.
- Top-chunk difference: SIGNED=0, a=0x80, b=0x7F -> out=100. With the macro defined, done follows edge 1. Without it, done follows edge 4.
- Signed mode: SIGNED=1, a=0x80 (-128), b=0x7F (+127) -> out=001. Then a=0xFF, b=0xFE -> out=100.
- Ignored start and back-to-back: a=0x10, b=0x11, start held high through the scan -> one result, out=001 at the first done. With start=1 in the DONE cycle and a=0x22, b=0x22, the second compare is accepted, out clears to 000, and the next result is 010.
- Reset mid-scan: start a=0x01, b=0x02, drop rst_n after edge 2 -> busy=0, done=0, out=000 immediately, and no done pulse after release.
